prefetch_cache_ctrl: RTL and testbench

- FSM sequencing the 2-way, 8-set, 256-bit-line prefetch cache datapath.
- Arbitrates the single datapath between CPU read/write requests and prefetcher line-install requests.
- Drives every datapath select and load strobe, plus the pmem and prefetcher handshakes.
- Sits between the bus adapter, cacheline adapter, prefetcher and the datapath.

---
 rtl/prefetch_cache_ctrl_if.sv | 33 +++
 rtl/prefetch_cache_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_prefetch_cache_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_cache_ctrl_if.sv
// Control/status bundle between prefetch_cache_ctrl and the datapath,
// bus adapter, cacheline adapter and prefetcher.
// master: the controller; slave: the surrounding blocks.
`timescale 1ns/1ps
interface prefetch_cache_ctrl_if;
  logic       mem_read, mem_write, mem_resp;
  logic       pmem_read, pmem_write, pmem_resp;
  logic       prefetch_ready, prefetch_ack;
  logic       miss, way, dirty_out;
  logic [1:0] data_in_sel;
  logic       pmem_addr_sel;
  logic [1:0] wr_en_data_0_sel, wr_en_data_1_sel;
  logic       dirty_in, valid_in;
  logic       ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1;
  logic       ld_tag_0, ld_tag_1, ld_lru;
  logic       index_sel, tag_sel;

  modport master (
    input  mem_read, mem_write, pmem_resp, prefetch_ready, miss, way, dirty_out,
    output mem_resp, pmem_read, pmem_write, prefetch_ack, data_in_sel,
           pmem_addr_sel, wr_en_data_0_sel, wr_en_data_1_sel, dirty_in, valid_in,
           ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1, ld_tag_0, ld_tag_1,
           ld_lru, index_sel, tag_sel
  );

  modport slave (
    output mem_read, mem_write, pmem_resp, prefetch_ready, miss, way, dirty_out,
    input  mem_resp, pmem_read, pmem_write, prefetch_ack, data_in_sel,
           pmem_addr_sel, wr_en_data_0_sel, wr_en_data_1_sel, dirty_in, valid_in,
           ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1, ld_tag_0, ld_tag_1,
           ld_lru, index_sel, tag_sel
  );
endinterface

// File: rtl/prefetch_cache_ctrl.sv
// Sequencer for the 2-way, 8-set prefetch cache datapath. Arbitrates between
// CPU requests and prefetcher line installs, with a starvation limit that
// forces a pending prefetch after STARVE_LIMIT CPU completions.
// Optional performance counters: define PREFETCH_CACHE_CTRL_PERF_CNT_EN.
`timescale 1ns/1ps
module prefetch_cache_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  prefetch_cache_ctrl_if.master bus
`ifdef PREFETCH_CACHE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] pf_install_cnt,
  output logic [CNT_WIDTH-1:0] pf_drop_cnt
`endif
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT    = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STV_ONE  = SW'(1);

  if (STARVE_LIMIT < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("prefetch_cache_ctrl: STARVE_LIMIT and CNT_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WB, S_FILL, S_PF_CHECK, S_PF_WB, S_PF_INSTALL
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cpu_req, pf_win;
  logic          line_ld, byte_wr;

  assign cpu_req = bus.mem_read | bus.mem_write;
  assign pf_win  = bus.prefetch_ready & (~cpu_req | (starve_q == LIMIT));

  // Next state and all datapath strobes, decoded from state and status inputs
  always_comb begin
    state_d               = state_q;
    line_ld               = 1'b0;
    byte_wr               = 1'b0;
    bus.mem_resp          = 1'b0;
    bus.pmem_read         = 1'b0;
    bus.pmem_write        = 1'b0;
    bus.prefetch_ack      = 1'b0;
    bus.data_in_sel       = 2'b00;
    bus.pmem_addr_sel     = 1'b0;
    bus.wr_en_data_0_sel  = 2'b00;
    bus.wr_en_data_1_sel  = 2'b00;
    bus.dirty_in          = 1'b0;
    bus.valid_in          = 1'b0;
    bus.ld_dirty_0        = 1'b0;
    bus.ld_dirty_1        = 1'b0;
    bus.ld_valid_0        = 1'b0;
    bus.ld_valid_1        = 1'b0;
    bus.ld_tag_0          = 1'b0;
    bus.ld_tag_1          = 1'b0;
    bus.ld_lru            = 1'b0;
    bus.index_sel         = 1'b0;
    bus.tag_sel           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pf_win)       state_d = S_PF_CHECK;
        else if (cpu_req) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!bus.miss) begin
          bus.mem_resp = 1'b1;
          bus.ld_lru   = 1'b1;
          byte_wr      = bus.mem_write;
          state_d      = S_IDLE;
        end else begin
          state_d = bus.dirty_out ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        bus.pmem_read     = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          line_ld = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_PF_CHECK: begin
        bus.index_sel = 1'b1;
        bus.tag_sel   = 1'b1;
        if (!bus.miss) begin
          bus.prefetch_ack = 1'b1;
          state_d          = S_IDLE;
        end else begin
          state_d = bus.dirty_out ? S_PF_WB : S_PF_INSTALL;
        end
      end
      S_PF_WB: begin
        bus.index_sel  = 1'b1;
        bus.tag_sel    = 1'b1;
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) state_d = S_PF_INSTALL;
      end
      S_PF_INSTALL: begin
        bus.index_sel    = 1'b1;
        bus.tag_sel      = 1'b1;
        bus.data_in_sel  = 2'b11;
        bus.ld_lru       = 1'b1;
        bus.prefetch_ack = 1'b1;
        line_ld          = 1'b1;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Full-line install (pmem fill or prefetch) and CPU byte write share the
    // per-way strobe steering; the source mux is chosen in the case above.
    if (line_ld) begin
      bus.valid_in = 1'b1;
      if (bus.way) begin
        bus.wr_en_data_1_sel = 2'b01;
        bus.ld_tag_1         = 1'b1;
        bus.ld_valid_1       = 1'b1;
        bus.ld_dirty_1       = 1'b1;
      end else begin
        bus.wr_en_data_0_sel = 2'b01;
        bus.ld_tag_0         = 1'b1;
        bus.ld_valid_0       = 1'b1;
        bus.ld_dirty_0       = 1'b1;
      end
    end
    if (byte_wr) begin
      bus.data_in_sel = 2'b01;
      bus.dirty_in    = 1'b1;
      if (bus.way) begin
        bus.wr_en_data_1_sel = 2'b10;
        bus.ld_dirty_1       = 1'b1;
      end else begin
        bus.wr_en_data_0_sel = 2'b10;
        bus.ld_dirty_0       = 1'b1;
      end
    end
  end

  // Starvation counter: CPU completions while a prefetch waits, cleared on ack
  always_comb begin
    starve_d = starve_q;
    if (bus.prefetch_ack)
      starve_d = '0;
    else if (bus.mem_resp && bus.prefetch_ready && starve_q != LIMIT)
      starve_d = starve_q + STV_ONE;
  end

  // State and starvation counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

`ifdef PREFETCH_CACHE_CTRL_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 first_chk_q;
  logic [CNT_WIDTH-1:0] hit_q, miss_q, inst_q, drop_q;
  logic                 first_chk_d, hit_inc, miss_inc, inst_inc, drop_inc;

  assign first_chk_d = (state_q == S_IDLE) && (state_d == S_CHECK);
  assign hit_inc     = (state_q == S_CHECK) && first_chk_q && !bus.miss;
  assign miss_inc    = (state_q == S_CHECK) && first_chk_q &&  bus.miss;
  assign inst_inc    = (state_q == S_PF_INSTALL);
  assign drop_inc    = (state_q == S_PF_CHECK) && !bus.miss;

  // Saturating event counters; only the lookup entered from IDLE is counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_chk_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      inst_q      <= '0;
      drop_q      <= '0;
    end else begin
      first_chk_q <= first_chk_d;
      if (hit_inc  && hit_q  != '1) hit_q  <= hit_q  + CNT_ONE;
      if (miss_inc && miss_q != '1) miss_q <= miss_q + CNT_ONE;
      if (inst_inc && inst_q != '1) inst_q <= inst_q + CNT_ONE;
      if (drop_inc && drop_q != '1) drop_q <= drop_q + CNT_ONE;
    end
  end

  assign hit_cnt        = hit_q;
  assign miss_cnt       = miss_q;
  assign pf_install_cnt = inst_q;
  assign pf_drop_cnt    = drop_q;
`else
`endif

endmodule

// File: tb/tb_prefetch_cache_ctrl.sv
// Self-checking bench for prefetch_cache_ctrl. Each transaction is expanded
// into its expected per-cycle strobe pattern from its parameters (hit/miss,
// victim dirtiness, pmem latencies) and the arbitration/starvation rules.
`timescale 1ns/1ps
module tb_prefetch_cache_ctrl;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned CW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefetch_cache_ctrl_if bus();
`ifdef PREFETCH_CACHE_CTRL_PERF_CNT_EN
  logic [CW-1:0] hit_cnt, miss_cnt, pf_install_cnt, pf_drop_cnt;
`endif

  prefetch_cache_ctrl #(.STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef PREFETCH_CACHE_CTRL_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .pf_install_cnt(pf_install_cnt), .pf_drop_cnt(pf_drop_cnt)
`endif
  );

  typedef struct packed {
    logic       mem_resp, pmem_read, pmem_write, prefetch_ack;
    logic [1:0] data_in_sel;
    logic       pmem_addr_sel;
    logic [1:0] wr0, wr1;
    logic       dirty_in, valid_in;
    logic       ld_dirty_0, ld_dirty_1, ld_valid_0, ld_valid_1;
    logic       ld_tag_0, ld_tag_1, ld_lru;
    logic       index_sel, tag_sel;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  presp;
    logic  inst;
  } step_t;

  int    checks = 0;
  int    failures = 0;
  step_t q[$];

  bit          cpu_pend, cpu_wr, cpu_res, cpu_vd, cpu_way;
  int unsigned cpu_lw, cpu_lr;
  bit          pf_pend, pf_res, pf_vd, pf_way;
  int unsigned pf_lw;
  int unsigned starve;
  int unsigned m_hit, m_miss, m_inst, m_drop;

  function automatic outs_t get_outs();
    outs_t o;
    o.mem_resp = bus.mem_resp;       o.pmem_read = bus.pmem_read;
    o.pmem_write = bus.pmem_write;   o.prefetch_ack = bus.prefetch_ack;
    o.data_in_sel = bus.data_in_sel; o.pmem_addr_sel = bus.pmem_addr_sel;
    o.wr0 = bus.wr_en_data_0_sel;    o.wr1 = bus.wr_en_data_1_sel;
    o.dirty_in = bus.dirty_in;       o.valid_in = bus.valid_in;
    o.ld_dirty_0 = bus.ld_dirty_0;   o.ld_dirty_1 = bus.ld_dirty_1;
    o.ld_valid_0 = bus.ld_valid_0;   o.ld_valid_1 = bus.ld_valid_1;
    o.ld_tag_0 = bus.ld_tag_0;       o.ld_tag_1 = bus.ld_tag_1;
    o.ld_lru = bus.ld_lru;
    o.index_sel = bus.index_sel;     o.tag_sel = bus.tag_sel;
    return o;
  endfunction

  function automatic outs_t line_load(input outs_t b, input bit w, input logic [1:0] src);
    outs_t o = b;
    o.data_in_sel = src;
    o.valid_in = 1'b1;
    o.dirty_in = 1'b0;
    if (w) begin o.wr1 = 2'b01; o.ld_tag_1 = 1'b1; o.ld_valid_1 = 1'b1; o.ld_dirty_1 = 1'b1; end
    else   begin o.wr0 = 2'b01; o.ld_tag_0 = 1'b1; o.ld_valid_0 = 1'b1; o.ld_dirty_0 = 1'b1; end
    return o;
  endfunction

  function automatic outs_t o_cpu_resp(input bit wr, input bit w);
    outs_t o = '0;
    o.mem_resp = 1'b1;
    o.ld_lru = 1'b1;
    if (wr) begin
      o.data_in_sel = 2'b01;
      o.dirty_in = 1'b1;
      if (w) begin o.wr1 = 2'b10; o.ld_dirty_1 = 1'b1; end
      else   begin o.wr0 = 2'b10; o.ld_dirty_0 = 1'b1; end
    end
    return o;
  endfunction

  function automatic outs_t o_wb(input bit pf);
    outs_t o = '0;
    o.pmem_write = 1'b1;
    o.index_sel = pf;
    o.tag_sel = pf;
    return o;
  endfunction

  function automatic outs_t o_fill();
    outs_t o = '0;
    o.pmem_read = 1'b1;
    o.pmem_addr_sel = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_pf_look(input bit hit);
    outs_t o = '0;
    o.index_sel = 1'b1;
    o.tag_sel = 1'b1;
    o.prefetch_ack = hit;
    return o;
  endfunction

  function automatic outs_t o_pf_inst(input bit w);
    outs_t o = line_load(o_pf_look(1'b1), w, 2'b11);
    o.ld_lru = 1'b1;
    return o;
  endfunction

  function automatic logic stray();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic void push(input outs_t o, input logic presp, input logic inst);
    step_t e;
    e.o = o; e.presp = presp; e.inst = inst;
    q.push_back(e);
  endfunction

  // Expected cycles of one CPU transaction, starting with the IDLE cycle
  function automatic void build_cpu();
    push('0, stray(), 1'b0);
    if (cpu_res) begin
      push(o_cpu_resp(cpu_wr, cpu_way), stray(), 1'b0);
    end else begin
      push('0, stray(), 1'b0);
      if (cpu_vd)
        for (int unsigned i = 0; i < cpu_lw; i++) push(o_wb(1'b0), i == cpu_lw - 1, 1'b0);
      for (int unsigned i = 0; i < cpu_lr; i++) begin
        if (i == cpu_lr - 1) push(line_load(o_fill(), cpu_way, 2'b00), 1'b1, 1'b1);
        else                 push(o_fill(), 1'b0, 1'b0);
      end
      push(o_cpu_resp(cpu_wr, cpu_way), stray(), 1'b0);
    end
  endfunction

  // Expected cycles of one prefetch transaction, starting with the IDLE cycle
  function automatic void build_pf();
    push('0, stray(), 1'b0);
    if (pf_res) begin
      push(o_pf_look(1'b1), stray(), 1'b0);
    end else begin
      push(o_pf_look(1'b0), stray(), 1'b0);
      if (pf_vd)
        for (int unsigned i = 0; i < pf_lw; i++) push(o_wb(1'b1), i == pf_lw - 1, 1'b0);
      push(o_pf_inst(pf_way), stray(), 1'b0);
    end
  endfunction

  // Plays queued steps: drives responder inputs, compares all outputs mid-cycle
  task automatic run_queue(input string name, input int unsigned max);
    int unsigned n = 0;
    step_t e;
    outs_t s;
    while (q.size() > 0 && n < max) begin
      e = q.pop_front();
      bus.pmem_resp = e.presp;
      if (e.o.index_sel) begin bus.miss = !pf_res;  bus.way = pf_way;  bus.dirty_out = pf_vd;  end
      else               begin bus.miss = !cpu_res; bus.way = cpu_way; bus.dirty_out = cpu_vd; end
      @(negedge clk);
      s = get_outs();
      checks++;
      if (s !== e.o) begin
        failures++;
        $display("FAIL %s step%0d outs=%h expected=%h", name, n, s, e.o);
      end
      @(posedge clk); #1;
      if (e.inst) cpu_res = 1'b1;
      n++;
    end
    bus.pmem_resp = 1'b0;
  endtask

  task automatic start_cpu(input bit wr, input bit hit, input bit vd, input bit w,
                           input int unsigned lw, input int unsigned lr);
    cpu_wr = wr; cpu_res = hit; cpu_vd = vd; cpu_way = w; cpu_lw = lw; cpu_lr = lr;
    cpu_pend = 1'b1;
    bus.mem_read = !wr;
    bus.mem_write = wr;
  endtask

  task automatic start_pf(input bit hit, input bit vd, input bit w, input int unsigned lw);
    pf_res = hit; pf_vd = vd; pf_way = w; pf_lw = lw;
    pf_pend = 1'b1;
    bus.prefetch_ready = 1'b1;
  endtask

  // One arbitration round: predicts the winner and plays its transaction
  task automatic slot(input string name);
    if (cpu_pend && (!pf_pend || starve != LIMIT)) begin
      if (cpu_res) m_hit++; else m_miss++;
      build_cpu();
      run_queue({name, "_cpu"}, 1000);
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; cpu_pend = 1'b0;
      if (pf_pend && starve < LIMIT) starve++;
    end else if (pf_pend) begin
      if (pf_res) m_drop++; else m_inst++;
      build_pf();
      run_queue({name, "_pf"}, 1000);
      bus.prefetch_ready = 1'b0; pf_pend = 1'b0;
      starve = 0;
    end
  endtask

  task automatic model_reset();
    cpu_pend = 0; pf_pend = 0; starve = 0;
    m_hit = 0; m_miss = 0; m_inst = 0; m_drop = 0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_counters(input string name);
`ifdef PREFETCH_CACHE_CTRL_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (hit_cnt !== CW'(m_hit) || miss_cnt !== CW'(m_miss) ||
        pf_install_cnt !== CW'(m_inst) || pf_drop_cnt !== CW'(m_drop)) begin
      failures++;
      $display("FAIL %s counters hit/miss/inst/drop=%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d",
               name, hit_cnt, miss_cnt, pf_install_cnt, pf_drop_cnt, m_hit, m_miss, m_inst, m_drop);
    end
    @(posedge clk); #1;
`else
    if (name.len() == 0) $display("counters not built");
`endif
  endtask

  task automatic test_reset();
    outs_t s;
    rst = 1'b0;
    bus.mem_read = 1'b1; bus.prefetch_ready = 1'b1; bus.pmem_resp = 1'b1; bus.miss = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s = get_outs();
      checks++;
      if (s !== '0) begin failures++; $display("FAIL reset_outs outs=%h expected=0", s); end
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.prefetch_ready = 1'b0; bus.pmem_resp = 1'b0; bus.miss = 1'b0;
    rst = 1'b1;
    model_reset();
    check_counters("reset");
  endtask

  task automatic test_read_miss_clean();
    start_cpu(1'b0, 1'b0, 1'b0, 1'b0, 1, 5);
    slot("read_miss_clean");
  endtask

  task automatic test_write_hit();
    start_cpu(1'b1, 1'b1, 1'b0, 1'b1, 1, 1);
    slot("write_hit_way1");
  endtask

  task automatic test_dirty_miss();
    start_cpu(1'b0, 1'b0, 1'b1, 1'b1, 3, 4);
    slot("read_miss_dirty");
    start_cpu(1'b1, 1'b0, 1'b1, 1'b0, 1, 1);
    slot("write_miss_dirty_lat1");
  endtask

  task automatic test_pf_drop();
    do_reset();
    start_pf(1'b1, 1'b0, 1'b0, 1);
    slot("pf_resident");
    check_counters("pf_drop");
  endtask

  task automatic test_pf_install();
    start_pf(1'b0, 1'b0, 1'b1, 1);
    slot("pf_install_clean");
    start_pf(1'b0, 1'b1, 1'b0, 3);
    slot("pf_install_dirty");
  endtask

  task automatic test_starvation();
    do_reset();
    start_pf(1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 6; i++) begin
      if (!cpu_pend) start_cpu(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1, 1);
      slot("starve");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) begin
      if (!cpu_pend && $urandom_range(0, 2) != 0)
        start_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(1, 4), $urandom_range(1, 4));
      if (!pf_pend && $urandom_range(0, 2) == 0)
        start_pf(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 4));
      if (!cpu_pend && !pf_pend)
        start_cpu(1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
      slot("random");
    end
    while (cpu_pend || pf_pend) slot("random_drain");
    check_counters("random");
  endtask

  task automatic test_reset_mid_wb();
    outs_t s;
    start_cpu(1'b0, 1'b0, 1'b1, 1'b0, 50, 2);
    build_cpu();
    run_queue("pre_reset_wb", 4);
    rst = 1'b0;
    #1;
    s = get_outs();
    checks++;
    if (s !== '0) begin failures++; $display("FAIL reset_in_wb outs=%h expected=0", s); end
    bus.mem_read = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) push('0, 1'b1, 1'b0);
    run_queue("after_reset_idle", 100);
    check_counters("after_reset");
    start_cpu(1'b1, 1'b1, 1'b0, 1'b0, 1, 1);
    slot("after_reset_write_hit");
  endtask

  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0; bus.prefetch_ready = 0;
    bus.miss = 0; bus.way = 0; bus.dirty_out = 0;
    model_reset();
    test_reset();
    test_read_miss_clean();
    test_write_hit();
    test_dirty_miss();
    test_pf_drop();
    test_pf_install();
    test_starvation();
    test_random();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
